// File: rtl/uci_move_pkg.sv
// Shared move record passed from uci_move_parser to move_executor.
package uci_move_pkg;

    typedef enum logic [2:0] {
        SPECIAL_UNKNOWN        = 3'd0,
        SPECIAL_PROMOTE_KNIGHT = 3'd1,
        SPECIAL_PROMOTE_BISHOP = 3'd2,
        SPECIAL_PROMOTE_ROOK   = 3'd3,
        SPECIAL_PROMOTE_QUEEN  = 3'd4
    } special_e;

    // Square coordinate = rnk*8 + fil.
    typedef struct packed {
        logic [5:0] src;
        logic [5:0] dst;
        special_e   special;
    } move_t;

endpackage

// File: rtl/uci_move_parser.sv
// Byte-serial long-algebraic move parser with a one-entry move register and valid/ready output.
// Optional feature macro UCI_UPPERCASE_EN: accept uppercase files and promotion letters.
module uci_move_parser
    import uci_move_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] byte_in,
    input  logic       byte_valid_in,
    output logic       byte_ready_out,
    output move_t      move_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       error_out
);

    typedef enum logic [2:0] {
        StSrcFil,
        StSrcRnk,
        StDstFil,
        StDstRnk,
        StPromo,
        StEnd,
        StDrop,
        StEmit
    } state_e;

    state_e     r_state;
    logic [2:0] r_src_fil;
    logic [2:0] r_src_rnk;
    logic [2:0] r_dst_fil;
    logic [2:0] r_dst_rnk;
    special_e   r_special;
    move_t      r_move;
    logic       r_valid;
    logic       r_error;

    logic [7:0] w_lc;
    logic [2:0] w_idx;
    logic       w_is_file;
    logic       w_is_rank;
    logic       w_is_term;
    logic       w_is_promo;
    special_e   w_promo_special;

`ifdef UCI_UPPERCASE_EN
    // Fold 'A'..'Z' onto lowercase so one set of decoders serves both cases.
    assign w_lc = (byte_in >= 8'h41 && byte_in <= 8'h5a) ? (byte_in | 8'h20) : byte_in;
`else
    assign w_lc = byte_in;
`endif

    // 'a'..'h' and '1'..'8' both start at a low nibble of 1, so one subtract covers both.
    assign w_idx     = byte_in[2:0] - 3'd1;
    assign w_is_file = (w_lc >= 8'h61) && (w_lc <= 8'h68);
    assign w_is_rank = (byte_in >= 8'h31) && (byte_in <= 8'h38);
    assign w_is_term = (byte_in == 8'h20) || (byte_in == 8'h0a) || (byte_in == 8'h0d);

    always_comb begin
        w_is_promo      = 1'b1;
        w_promo_special = SPECIAL_UNKNOWN;
        case (w_lc)
            8'h6e:   w_promo_special = SPECIAL_PROMOTE_KNIGHT;
            8'h62:   w_promo_special = SPECIAL_PROMOTE_BISHOP;
            8'h72:   w_promo_special = SPECIAL_PROMOTE_ROOK;
            8'h71:   w_promo_special = SPECIAL_PROMOTE_QUEEN;
            default: w_is_promo      = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= StSrcFil;
            r_src_fil <= 3'd0;
            r_src_rnk <= 3'd0;
            r_dst_fil <= 3'd0;
            r_dst_rnk <= 3'd0;
            r_special <= SPECIAL_UNKNOWN;
            r_move    <= '0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_error <= 1'b0;
            if (r_state == StEmit) begin
                if (ready_in) begin
                    r_state <= StSrcFil;
                    r_valid <= 1'b0;
                end
            end else if (byte_valid_in) begin
                unique case (r_state)
                    StSrcFil: begin
                        if (w_is_file) begin
                            r_src_fil <= w_idx;
                            r_state   <= StSrcRnk;
                        end else if (!w_is_term) begin
                            r_error <= 1'b1;
                            r_state <= StDrop;
                        end
                    end
                    StSrcRnk: begin
                        if (w_is_rank) begin
                            r_src_rnk <= w_idx;
                            r_state   <= StDstFil;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= w_is_term ? StSrcFil : StDrop;
                        end
                    end
                    StDstFil: begin
                        if (w_is_file) begin
                            r_dst_fil <= w_idx;
                            r_state   <= StDstRnk;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= w_is_term ? StSrcFil : StDrop;
                        end
                    end
                    StDstRnk: begin
                        if (w_is_rank) begin
                            r_dst_rnk <= w_idx;
                            r_state   <= StPromo;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= w_is_term ? StSrcFil : StDrop;
                        end
                    end
                    StPromo: begin
                        if (w_is_term) begin
                            r_move.src     <= {r_src_rnk, r_src_fil};
                            r_move.dst     <= {r_dst_rnk, r_dst_fil};
                            r_move.special <= SPECIAL_UNKNOWN;
                            r_valid        <= 1'b1;
                            r_state        <= StEmit;
                        end else if (w_is_promo) begin
                            r_special <= w_promo_special;
                            r_state   <= StEnd;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= StDrop;
                        end
                    end
                    StEnd: begin
                        if (w_is_term) begin
                            r_move.src     <= {r_src_rnk, r_src_fil};
                            r_move.dst     <= {r_dst_rnk, r_dst_fil};
                            r_move.special <= r_special;
                            r_valid        <= 1'b1;
                            r_state        <= StEmit;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= StDrop;
                        end
                    end
                    StDrop: begin
                        if (w_is_term) begin
                            r_state <= StSrcFil;
                        end
                    end
                    StEmit: begin
                    end
                endcase
            end
        end
    end

    assign byte_ready_out = (r_state != StEmit);
    assign move_out       = r_move;
    assign valid_out      = r_valid;
    assign error_out      = r_error;

endmodule
